// File: rtl/memory_read_multi_pkg.sv
// Shared definitions for the multi-piece linear read splitter:
// boolean constants, state encoding and parameter-derived sizes.
package memory_read_multi_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PIECE = 2'd1,
    ZERO  = 2'd2
  } read_state_t;

  // Worst-case number of line-bounded pieces for an access of max_len bytes.
  function automatic int max_pieces(input int line_bytes, input int max_len);
    return (max_len - 1 + line_bytes - 1) / line_bytes + 1;
  endfunction

endpackage

// File: rtl/memory_read_frag.sv
// Combinational piece calculator: address, length and last-piece flag of
// piece 'index' of a linear read split on LINE_BYTES boundaries.
module memory_read_frag #(
  parameter int LINE_BYTES = 16,
  parameter int LW         = 4,
  parameter int PW         = 2
) (
  input  logic [31:0]   start_address,
  input  logic [LW-1:0] length,
  input  logic [PW-1:0] index,
  output logic [31:0]   address,
  output logic [LW-1:0] piece_length,
  output logic          last
);

  localparam int          OW   = $clog2(LINE_BYTES);
  localparam logic [31:0] LINE = 32'(LINE_BYTES);

  logic [31:0] offset, line_base, head, span, consumed, remaining, limit;

  always_comb begin
    offset    = {{(32-OW){1'b0}}, start_address[OW-1:0]};
    line_base = start_address & ~(LINE - 32'd1);
    head      = LINE - offset;
    if (index == '0) begin
      address  = start_address;
      span     = head;
      consumed = '0;
    end else begin
      // Later pieces start on line boundaries; address arithmetic wraps at 2^32.
      address  = line_base + (32'(index) << OW);
      span     = LINE;
      consumed = head + ((32'(index) - 32'd1) << OW);
    end
    remaining    = (32'(length) > consumed) ? 32'(length) - consumed : '0;
    limit        = (remaining < span) ? remaining : span;
    piece_length = LW'(limit);
    last         = (offset + 32'(length)) <= ((32'(index) + 32'd1) << OW);
  end

endmodule

// File: rtl/memory_read_multi.sv
// Splits a linear read of up to MAX_LEN bytes into ascending line-bounded TLB
// reads, merges the returned bytes little-endian and tracks sticky faults.
module memory_read_multi
  import memory_read_multi_pkg::*;
#(
  parameter  int LINE_BYTES = 16,
  parameter  int MAX_LEN    = 8,
  localparam int LW         = $clog2(MAX_LEN + 1),
  localparam int DW         = 8 * MAX_LEN,
  localparam int PW         = $clog2(max_pieces(LINE_BYTES, MAX_LEN) + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_reset,
  input  logic          read_do,
  input  logic [1:0]    read_cpl,
  input  logic [31:0]   read_address,
  input  logic [LW-1:0] read_length,
  input  logic          read_lock,
  input  logic          read_rmw,
  output logic          read_done,
  output logic [DW-1:0] read_data,
  output logic          read_page_fault,
  output logic          read_ac_fault,
  output logic [PW-1:0] read_fault_piece,
  output logic [31:0]   read_fault_address,
  output logic          tlbread_do,
  output logic [31:0]   tlbread_address,
  output logic [LW-1:0] tlbread_length,
  output logic [LW-1:0] tlbread_length_full,
  output logic [1:0]    tlbread_cpl,
  output logic          tlbread_lock,
  output logic          tlbread_rmw,
  input  logic          tlbread_done,
  input  logic          tlbread_page_fault,
  input  logic          tlbread_ac_fault,
  input  logic          tlbread_retry,
  input  logic [DW-1:0] tlbread_data
);

  read_state_t   state;
  logic [PW-1:0] index, frag_index;
  logic [LW-1:0] acc;
  logic [DW-1:0] acc_data, piece_mask, merged;
  logic          reset_waiting, sticky, accept, piece_last, piece_fault;

  assign sticky      = read_page_fault | read_ac_fault;
  assign accept      = (state == IDLE) && read_do && !read_done && !rd_reset && !sticky;
  assign piece_fault = tlbread_page_fault | tlbread_ac_fault;
  assign frag_index  = (state == PIECE) ? index : '0;

  memory_read_frag #(
    .LINE_BYTES (LINE_BYTES),
    .LW         (LW),
    .PW         (PW)
  ) u_frag (
    .start_address (read_address),
    .length        (read_length),
    .index         (frag_index),
    .address       (tlbread_address),
    .piece_length  (tlbread_length),
    .last          (piece_last)
  );

  assign tlbread_do          = accept || (state == PIECE);
  assign tlbread_length_full = read_length;
  assign tlbread_cpl         = read_cpl;
  assign tlbread_lock        = read_lock;
  assign tlbread_rmw         = read_rmw;

  // Only the valid low bytes of a piece are merged, at the running byte offset.
  always_comb begin
    piece_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      if (i < 32'(tlbread_length)) piece_mask[8*i +: 8] = '1;
    merged = acc_data | ((tlbread_data & piece_mask) << {acc, 3'b000});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      index              <= '0;
      acc                <= '0;
      acc_data           <= '0;
      reset_waiting      <= FALSE;
      read_done          <= FALSE;
      read_data          <= '0;
      read_page_fault    <= FALSE;
      read_ac_fault      <= FALSE;
      read_fault_piece   <= '0;
      read_fault_address <= '0;
    end else begin
      if (rd_reset) begin
        read_page_fault <= FALSE;
        read_ac_fault   <= FALSE;
      end else if (state == PIECE && !reset_waiting && piece_fault) begin
        if (tlbread_page_fault) read_page_fault <= TRUE;
        if (tlbread_ac_fault)   read_ac_fault   <= TRUE;
        read_fault_piece   <= index;
        read_fault_address <= tlbread_address;
      end

      case (state)
        IDLE: begin
          read_done     <= FALSE;
          reset_waiting <= FALSE;
          if (accept) begin
            index    <= '0;
            acc      <= '0;
            acc_data <= '0;
            state    <= (read_length == '0) ? ZERO : PIECE;
          end
        end
        PIECE: begin
          if (rd_reset) reset_waiting <= TRUE;
          if (piece_fault) begin
            state <= IDLE;
          end else if (tlbread_done) begin
            acc_data <= merged;
            acc      <= acc + tlbread_length;
            index    <= index + 1'b1;
            if (piece_last) begin
              state <= IDLE;
              if (!rd_reset && !reset_waiting) begin
                read_done <= TRUE;
                read_data <= merged;
              end
            end
          end else if (tlbread_retry && reset_waiting) begin
            state <= IDLE;
          end
        end
        ZERO: begin
          read_done <= TRUE;
          read_data <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_read_multi.sv
// Directed bench for memory_read_multi: 16-byte lines / 8-byte accesses and
// 4-byte lines / 16-byte accesses, with a scripted single-cycle TLB.
module tb_memory_read_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rd_reset, read_lock, read_rmw;
  logic [1:0]  read_cpl;
  logic [31:0] read_address;
  logic        tlbread_page_fault, tlbread_ac_fault, tlbread_retry;

  // Instance A: LINE_BYTES 16, MAX_LEN 8
  logic        read_do, read_done, read_page_fault, read_ac_fault;
  logic [3:0]  read_length, tlbread_length, tlbread_length_full;
  logic [63:0] read_data, tlbread_data;
  logic [1:0]  read_fault_piece, tlbread_cpl;
  logic [31:0] read_fault_address, tlbread_address;
  logic        tlbread_do, tlbread_lock, tlbread_rmw, tlbread_done;

  // Instance B: LINE_BYTES 4, MAX_LEN 16
  logic         read_do_b, read_done_b, read_page_fault_b, read_ac_fault_b;
  logic [4:0]   read_length_b, tlbread_length_b, tlbread_length_full_b;
  logic [127:0] read_data_b, tlbread_data_b;
  logic [2:0]   read_fault_piece_b;
  logic [1:0]   tlbread_cpl_b;
  logic [31:0]  read_fault_address_b, tlbread_address_b;
  logic         tlbread_do_b, tlbread_lock_b, tlbread_rmw_b, tlbread_done_b;

  int vectors = 0;
  int errors  = 0;

  memory_read_multi #(.LINE_BYTES(16), .MAX_LEN(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_reset(rd_reset), .read_do(read_do),
    .read_cpl(read_cpl), .read_address(read_address), .read_length(read_length),
    .read_lock(read_lock), .read_rmw(read_rmw), .read_done(read_done),
    .read_data(read_data), .read_page_fault(read_page_fault), .read_ac_fault(read_ac_fault),
    .read_fault_piece(read_fault_piece), .read_fault_address(read_fault_address),
    .tlbread_do(tlbread_do), .tlbread_address(tlbread_address), .tlbread_length(tlbread_length),
    .tlbread_length_full(tlbread_length_full), .tlbread_cpl(tlbread_cpl),
    .tlbread_lock(tlbread_lock), .tlbread_rmw(tlbread_rmw), .tlbread_done(tlbread_done),
    .tlbread_page_fault(tlbread_page_fault), .tlbread_ac_fault(tlbread_ac_fault),
    .tlbread_retry(tlbread_retry), .tlbread_data(tlbread_data)
  );

  memory_read_multi #(.LINE_BYTES(4), .MAX_LEN(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_reset(rd_reset), .read_do(read_do_b),
    .read_cpl(read_cpl), .read_address(read_address), .read_length(read_length_b),
    .read_lock(read_lock), .read_rmw(read_rmw), .read_done(read_done_b),
    .read_data(read_data_b), .read_page_fault(read_page_fault_b), .read_ac_fault(read_ac_fault_b),
    .read_fault_piece(read_fault_piece_b), .read_fault_address(read_fault_address_b),
    .tlbread_do(tlbread_do_b), .tlbread_address(tlbread_address_b), .tlbread_length(tlbread_length_b),
    .tlbread_length_full(tlbread_length_full_b), .tlbread_cpl(tlbread_cpl_b),
    .tlbread_lock(tlbread_lock_b), .tlbread_rmw(tlbread_rmw_b), .tlbread_done(tlbread_done_b),
    .tlbread_page_fault(tlbread_page_fault), .tlbread_ac_fault(tlbread_ac_fault),
    .tlbread_retry(tlbread_retry), .tlbread_data(tlbread_data_b)
  );

  task automatic test_reset();
    rst_n = 1'b0; rd_reset = 1'b0; read_do = 1'b0; read_do_b = 1'b0;
    read_cpl = 2'd0; read_lock = 1'b0; read_rmw = 1'b0; read_address = '0;
    read_length = '0; read_length_b = '0; tlbread_done = 1'b0; tlbread_done_b = 1'b0;
    tlbread_page_fault = 1'b0; tlbread_ac_fault = 1'b0; tlbread_retry = 1'b0;
    tlbread_data = '0; tlbread_data_b = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (read_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0h want 0", read_done); end
    vectors++; if (read_data !== 64'h0) begin errors++; $display("FAIL rst_data: got %0h want 0", read_data); end
    vectors++; if ({read_page_fault, read_ac_fault} !== 2'b00) begin errors++; $display("FAIL rst_faults: got %0b want 00", {read_page_fault, read_ac_fault}); end
    vectors++; if (read_fault_piece !== 2'd0 || read_fault_address !== 32'h0) begin errors++; $display("FAIL rst_fault_info: got %0h/%0h want 0/0", read_fault_piece, read_fault_address); end
    vectors++; if (tlbread_do !== 1'b0 || tlbread_do_b !== 1'b0) begin errors++; $display("FAIL rst_tlb_do: got %0b%0b want 00", tlbread_do, tlbread_do_b); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_piece();
    @(negedge clk);
    read_address = 32'h1003; read_length = 4'd4; read_cpl = 2'd3; read_lock = 1'b1; read_do = 1'b1; #1;
    vectors++; if (tlbread_do !== 1'b1) begin errors++; $display("FAIL single_accept_do: got %0b want 1", tlbread_do); end
    vectors++; if (tlbread_address !== 32'h1003 || tlbread_length !== 4'd4) begin errors++; $display("FAIL single_piece0: got %0h/%0d want 1003/4", tlbread_address, tlbread_length); end
    vectors++; if (tlbread_length_full !== 4'd4 || tlbread_cpl !== 2'd3 || tlbread_lock !== 1'b1 || tlbread_rmw !== 1'b0) begin errors++; $display("FAIL single_passthru: got %0d/%0d/%0b/%0b want 4/3/1/0", tlbread_length_full, tlbread_cpl, tlbread_lock, tlbread_rmw); end
    @(negedge clk); tlbread_done = 1'b1; tlbread_data = 64'hA1A2A3A4_B1B2B3B4; #1;
    vectors++; if (tlbread_do !== 1'b1 || tlbread_address !== 32'h1003) begin errors++; $display("FAIL single_issue: got %0b/%0h want 1/1003", tlbread_do, tlbread_address); end
    @(negedge clk); tlbread_done = 1'b0; read_do = 1'b0; read_cpl = 2'd0; read_lock = 1'b0; #1;
    vectors++; if (read_done !== 1'b1) begin errors++; $display("FAIL single_done: got %0b want 1", read_done); end
    vectors++; if (read_data !== 64'h00000000_B1B2B3B4) begin errors++; $display("FAIL single_data: got %0h want b1b2b3b4", read_data); end
    @(negedge clk); #1;
    vectors++; if (read_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %0b want 0", read_done); end
  endtask

  task automatic test_two_pieces();
    @(negedge clk);
    read_address = 32'h100D; read_length = 4'd8; read_do = 1'b1; #1;
    vectors++; if (tlbread_address !== 32'h100D || tlbread_length !== 4'd3) begin errors++; $display("FAIL two_piece0: got %0h/%0d want 100d/3", tlbread_address, tlbread_length); end
    // Retry with no flush pending must not disturb the piece.
    @(negedge clk); tlbread_retry = 1'b1; #1;
    @(negedge clk); tlbread_retry = 1'b0; tlbread_done = 1'b1; tlbread_data = 64'h11111111_11CCBBAA; #1;
    vectors++; if (tlbread_do !== 1'b1 || tlbread_address !== 32'h100D) begin errors++; $display("FAIL two_retry_ignored: got %0b/%0h want 1/100d", tlbread_do, tlbread_address); end
    @(negedge clk); tlbread_data = 64'h22222255_44332211; #1;
    vectors++; if (tlbread_do !== 1'b1 || tlbread_address !== 32'h1010 || tlbread_length !== 4'd5) begin errors++; $display("FAIL two_piece1: got %0b/%0h/%0d want 1/1010/5", tlbread_do, tlbread_address, tlbread_length); end
    vectors++; if (read_done !== 1'b0) begin errors++; $display("FAIL two_early_done: got %0b want 0", read_done); end
    @(negedge clk); tlbread_done = 1'b0; read_do = 1'b0; #1;
    vectors++; if (read_done !== 1'b1) begin errors++; $display("FAIL two_done: got %0b want 1", read_done); end
    vectors++; if (read_data !== 64'h55443322_11CCBBAA) begin errors++; $display("FAIL two_data: got %0h want 5544332211ccbbaa", read_data); end
  endtask

  task automatic test_five_pieces();
    logic [31:0] addrs [5] = '{32'h2003, 32'h2004, 32'h2008, 32'h200C, 32'h2010};
    logic [4:0]  lens  [5] = '{5'd1, 5'd4, 5'd4, 5'd4, 5'd3};
    @(negedge clk);
    read_address = 32'h2003; read_length_b = 5'd16; read_do_b = 1'b1; #1;
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      tlbread_done_b = 1'b1;
      tlbread_data_b = {16{8'(8'h11 * (p + 1))}};
      #1;
      vectors++; if (tlbread_do_b !== 1'b1 || tlbread_address_b !== addrs[p] || tlbread_length_b !== lens[p]) begin errors++; $display("FAIL five_piece%0d: got %0b/%0h/%0d want 1/%0h/%0d", p, tlbread_do_b, tlbread_address_b, tlbread_length_b, addrs[p], lens[p]); end
      vectors++; if (read_done_b !== 1'b0) begin errors++; $display("FAIL five_early_done%0d: got %0b want 0", p, read_done_b); end
    end
    @(negedge clk); tlbread_done_b = 1'b0; read_do_b = 1'b0; #1;
    vectors++; if (read_done_b !== 1'b1) begin errors++; $display("FAIL five_done: got %0b want 1", read_done_b); end
    vectors++; if (read_data_b !== 128'h555555_44444444_33333333_22222222_11) begin errors++; $display("FAIL five_data: got %0h want 55555544444444333333332222222211", read_data_b); end
  endtask

  task automatic test_page_fault_wrap();
    @(negedge clk);
    read_address = 32'hFFFFFFFE; read_length = 4'd4; read_do = 1'b1; #1;
    vectors++; if (tlbread_address !== 32'hFFFFFFFE || tlbread_length !== 4'd2) begin errors++; $display("FAIL pf_piece0: got %0h/%0d want fffffffe/2", tlbread_address, tlbread_length); end
    @(negedge clk); tlbread_done = 1'b1; tlbread_data = 64'h0; #1;
    // Fault arrives together with done: the fault must win.
    @(negedge clk); tlbread_page_fault = 1'b1; #1;
    vectors++; if (tlbread_address !== 32'h00000000 || tlbread_length !== 4'd2) begin errors++; $display("FAIL pf_piece1_wrap: got %0h/%0d want 0/2", tlbread_address, tlbread_length); end
    @(negedge clk); tlbread_done = 1'b0; tlbread_page_fault = 1'b0; #1;
    vectors++; if (read_page_fault !== 1'b1 || read_ac_fault !== 1'b0) begin errors++; $display("FAIL pf_flags: got %0b%0b want 10", read_page_fault, read_ac_fault); end
    vectors++; if (read_fault_piece !== 2'd1 || read_fault_address !== 32'h0) begin errors++; $display("FAIL pf_info: got %0d/%0h want 1/0", read_fault_piece, read_fault_address); end
    vectors++; if (read_done !== 1'b0) begin errors++; $display("FAIL pf_no_done: got %0b want 0", read_done); end
    @(negedge clk); #1;
    vectors++; if (tlbread_do !== 1'b0) begin errors++; $display("FAIL pf_sticky_block: got %0b want 0", tlbread_do); end
    read_do = 1'b0;
    @(negedge clk); rd_reset = 1'b1;
    @(negedge clk); rd_reset = 1'b0; #1;
    vectors++; if (read_page_fault !== 1'b0) begin errors++; $display("FAIL pf_clear: got %0b want 0", read_page_fault); end
  endtask

  task automatic test_ac_fault_priority();
    @(negedge clk);
    read_address = 32'h1003; read_length = 4'd4; read_do = 1'b1;
    @(negedge clk); tlbread_ac_fault = 1'b1; rd_reset = 1'b1; read_do = 1'b0;
    @(negedge clk); tlbread_ac_fault = 1'b0; rd_reset = 1'b0; #1;
    vectors++; if (read_ac_fault !== 1'b0 || read_done !== 1'b0 || tlbread_do !== 1'b0) begin errors++; $display("FAIL acp_reset_wins: got %0b/%0b/%0b want 0/0/0", read_ac_fault, read_done, tlbread_do); end
    @(negedge clk); read_do = 1'b1;
    @(negedge clk); tlbread_ac_fault = 1'b1;
    @(negedge clk); tlbread_ac_fault = 1'b0; read_do = 1'b0; #1;
    vectors++; if (read_ac_fault !== 1'b1 || read_page_fault !== 1'b0) begin errors++; $display("FAIL acp_flags: got %0b%0b want 01", read_page_fault, read_ac_fault); end
    vectors++; if (read_fault_piece !== 2'd0 || read_fault_address !== 32'h1003) begin errors++; $display("FAIL acp_info: got %0d/%0h want 0/1003", read_fault_piece, read_fault_address); end
    @(negedge clk); rd_reset = 1'b1;
    @(negedge clk); rd_reset = 1'b0; #1;
    vectors++; if (read_ac_fault !== 1'b0) begin errors++; $display("FAIL acp_clear: got %0b want 0", read_ac_fault); end
  endtask

  task automatic test_flush_retry();
    @(negedge clk);
    read_address = 32'h100D; read_length = 4'd8; read_do = 1'b1;
    @(negedge clk); tlbread_done = 1'b1; tlbread_data = 64'h0;
    @(negedge clk); tlbread_done = 1'b0; rd_reset = 1'b1; read_do = 1'b0; #1;
    vectors++; if (tlbread_address !== 32'h1010) begin errors++; $display("FAIL flush_piece1: got %0h want 1010", tlbread_address); end
    @(negedge clk); rd_reset = 1'b0; tlbread_retry = 1'b1; #1;
    vectors++; if (tlbread_do !== 1'b1) begin errors++; $display("FAIL flush_waiting_do: got %0b want 1", tlbread_do); end
    @(negedge clk); tlbread_retry = 1'b0; #1;
    vectors++; if (tlbread_do !== 1'b0 || read_done !== 1'b0 || {read_page_fault, read_ac_fault} !== 2'b00) begin errors++; $display("FAIL flush_idle: got %0b/%0b/%0b%0b want 0/0/00", tlbread_do, read_done, read_page_fault, read_ac_fault); end
    // A fault while the flush is pending ends the read without a sticky flag.
    @(negedge clk); read_address = 32'h1003; read_length = 4'd4; read_do = 1'b1;
    @(negedge clk); rd_reset = 1'b1; read_do = 1'b0;
    @(negedge clk); rd_reset = 1'b0; tlbread_page_fault = 1'b1;
    @(negedge clk); tlbread_page_fault = 1'b0; #1;
    vectors++; if (read_page_fault !== 1'b0 || tlbread_do !== 1'b0) begin errors++; $display("FAIL flush_fault_masked: got %0b/%0b want 0/0", read_page_fault, tlbread_do); end
    @(negedge clk); read_address = 32'h1003; read_length = 4'd4; read_do = 1'b1; #1;
    vectors++; if (tlbread_do !== 1'b1) begin errors++; $display("FAIL flush_reaccept: got %0b want 1", tlbread_do); end
    @(negedge clk); tlbread_done = 1'b1; tlbread_data = 64'hFFFFFFFF_DEADBEEF;
    @(negedge clk); tlbread_done = 1'b0; read_do = 1'b0; #1;
    vectors++; if (read_done !== 1'b1 || read_data !== 64'h00000000_DEADBEEF) begin errors++; $display("FAIL flush_new_read: got %0b/%0h want 1/deadbeef", read_done, read_data); end
  endtask

  task automatic test_zero_length();
    @(negedge clk);
    read_address = 32'h3000; read_length = 4'd0; read_do = 1'b1; #1;
    vectors++; if (tlbread_do !== 1'b1) begin errors++; $display("FAIL zero_accept_do: got %0b want 1", tlbread_do); end
    @(negedge clk); #1;
    vectors++; if (tlbread_do !== 1'b0 || read_done !== 1'b0) begin errors++; $display("FAIL zero_state: got %0b/%0b want 0/0", tlbread_do, read_done); end
    @(negedge clk); #1;
    vectors++; if (read_done !== 1'b1 || read_data !== 64'h0) begin errors++; $display("FAIL zero_done: got %0b/%0h want 1/0", read_done, read_data); end
    vectors++; if (tlbread_do !== 1'b0) begin errors++; $display("FAIL zero_no_reissue: got %0b want 0", tlbread_do); end
    read_do = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_piece();
    test_two_pieces();
    test_five_pieces();
    test_page_fault_wrap();
    test_ac_fault_priority();
    test_flush_retry();
    test_zero_length();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
